// File: rtl/m68k_bus_pkg.sv
// ============================================================================
// m68k_bus_pkg : shared types and helpers for the 68000 bus responder
// Rev 1.0
// ============================================================================
`default_nettype none

package m68k_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACK     = 3'd3,
    ST_RELEASE = 3'd4,
    ST_SKIP    = 3'd5
  } state_t;

  localparam logic [15:0] ID_VALUE_DEFAULT = 16'hB16A;

  // Lane vector bit positions: a set bit means that byte lane is strobed
  localparam int LANE_UPPER = 1;
  localparam int LANE_LOWER = 0;

  function automatic logic [15:0] merge_lanes(input logic [15:0] old_val,
                                               input logic [15:0] new_val,
                                               input logic [1:0]  lanes);
    logic [15:0] res;
    res = old_val;
    if (lanes[LANE_UPPER]) res[15:8] = new_val[15:8];
    if (lanes[LANE_LOWER]) res[7:0]  = new_val[7:0];
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/async_sync2.sv
// ============================================================================
// async_sync2 : two-flop synchronizer with a configurable reset value
// Rev 1.0
// ============================================================================
`default_nettype none

module async_sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/m68k_bus_responder.sv
// ============================================================================
// m68k_bus_responder : 68000 bus target with a small register file and
// programmable wait states. Define M68K_RESP_BERR_EN to answer illegal accesses with nBERR.
// Rev 1.0
// ============================================================================
`default_nettype none

module m68k_bus_responder
  import m68k_bus_pkg::*;
#(
  parameter logic [22:0] BASE_ADDR   = 23'h760000,
  parameter int          ADDR_BITS   = 4,
  parameter int          REG_COUNT   = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
  input  logic                   SYS_CLK,
  input  logic                   nRESET,
  input  logic [22:0]            A_IN,
  input  logic [15:0]            D_IN,
  input  logic                   RnW_IN,
  input  logic                   nAS_IN,
  input  logic                   nUDS_IN,
  input  logic                   nLDS_IN,
  output logic [15:0]            D_OUT,
  output logic                   D_OE,
  output logic                   nDTACK_OUT,
  output logic                   nDTACK_OE,
  output logic                   nBERR_OUT,
  output logic                   nBERR_OE,
  output logic [16*REG_COUNT-1:0] REGS_Q,
  output logic                   WR_STB,
  output logic [ADDR_BITS-1:0]   WR_IDX
);

  logic as_s, uds_s, lds_s, rnw_s;

  async_sync2 #(
    .WIDTH     (4),
    .RESET_VAL (4'b1111)
  ) u_sync (
    .clk   (SYS_CLK),
    .rst_n (nRESET),
    .d     ({nAS_IN, nUDS_IN, nLDS_IN, RnW_IN}),
    .q     ({as_s, uds_s, lds_s, rnw_s})
  );

  state_t               state, state_nx;
  logic [3:0]           cnt_q, cnt_nx;
  logic [ADDR_BITS-1:0] idx_q;
  logic                 rnw_q;
  logic [1:0]           lanes_q;
  logic [15:0]          wdata_q;

  logic                 start, hit;
  logic [ADDR_BITS-1:0] cur_idx;
  logic                 cur_rnw;
  logic [1:0]           cur_lanes;
  logic [15:0]          cur_wdata;
  logic                 cur_err;
  logic                 berr_sel;
  logic                 in_ack_nx, enter_ack, commit;
  logic [15:0]          rd_data;

  logic                 dtack_low;
  logic                 d_oe_q;
  logic [15:0]          d_out_q;
  logic                 wr_stb_q;
  logic [ADDR_BITS-1:0] wr_idx_q;

  assign start = !as_s && (rnw_s || !uds_s || !lds_s);
  assign hit   = (A_IN[22:ADDR_BITS] == BASE_ADDR[22:ADDR_BITS]);

  // In DECODE the cycle attributes are taken live so a zero-wait ACK entry sees them
  always_comb begin
    cur_idx   = idx_q;
    cur_rnw   = rnw_q;
    cur_lanes = lanes_q;
    cur_wdata = wdata_q;
    if (state == ST_DECODE) begin
      cur_idx   = A_IN[ADDR_BITS-1:0];
      cur_rnw   = rnw_s;
      cur_lanes = {!uds_s, !lds_s};
      cur_wdata = D_IN;
    end
  end

  assign cur_err = (!cur_rnw && (cur_idx == '0)) || (int'(cur_idx) >= REG_COUNT);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_q;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = hit ? ST_DECODE : ST_SKIP;
      end
      ST_DECODE: begin
        cnt_nx   = '0;
        state_nx = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
      end
      ST_WAIT: begin
        if (as_s)                                 state_nx = ST_IDLE;
        else if (cnt_q == 4'(WAIT_CYCLES - 1))    state_nx = ST_ACK;
        else                                      cnt_nx   = cnt_q + 4'd1;
      end
      ST_ACK: begin
        if (as_s) state_nx = ST_RELEASE;
      end
      ST_RELEASE: state_nx = ST_IDLE;
      ST_SKIP: begin
        if (as_s) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (!nRESET) begin
      state <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      cnt_q <= cnt_nx;
    end
  end

  assign in_ack_nx = (state_nx == ST_ACK);
  assign enter_ack = in_ack_nx && (state != ST_ACK);
  assign commit    = enter_ack && !cur_rnw && !cur_err && !berr_sel;

  always_comb begin
    rd_data = 16'h0000;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (cur_idx == ADDR_BITS'(i)) rd_data = REGS_Q[16*i +: 16];
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (!nRESET) begin
      idx_q     <= '0;
      rnw_q     <= 1'b1;
      lanes_q   <= '0;
      wdata_q   <= '0;
      dtack_low <= 1'b0;
      d_oe_q    <= 1'b0;
      d_out_q   <= '0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
    end else begin
      if (state == ST_DECODE) begin
        idx_q   <= cur_idx;
        rnw_q   <= cur_rnw;
        lanes_q <= cur_lanes;
        wdata_q <= cur_wdata;
      end
      dtack_low <= in_ack_nx && !berr_sel;
      d_oe_q    <= in_ack_nx && cur_rnw && !berr_sel;
      d_out_q   <= (in_ack_nx && cur_rnw && !berr_sel) ? rd_data : 16'h0000;
      wr_stb_q  <= commit;
      if (commit) wr_idx_q <= cur_idx;
    end
  end

  // Register 0 is the read-only ID; writable registers start at 1
  assign REGS_Q[15:0] = ID_VALUE;

  for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
    logic [15:0] val;
    always_ff @(posedge SYS_CLK) begin
      if (!nRESET) begin
        val <= '0;
      end else if (commit && (cur_idx == ADDR_BITS'(i))) begin
        val <= merge_lanes(val, cur_wdata, cur_lanes);
      end
    end
    assign REGS_Q[16*i +: 16] = val;
  end

`ifdef M68K_RESP_BERR_EN
  logic berr_low;

  assign berr_sel = cur_err;

  always_ff @(posedge SYS_CLK) begin
    if (!nRESET) berr_low <= 1'b0;
    else         berr_low <= in_ack_nx && berr_sel;
  end

  assign nBERR_OE  = berr_low;
  assign nBERR_OUT = !berr_low;
`else
  assign berr_sel  = 1'b0;
  assign nBERR_OE  = 1'b0;
  assign nBERR_OUT = 1'b1;
`endif

  assign D_OUT      = d_out_q;
  assign D_OE       = d_oe_q;
  assign nDTACK_OE  = dtack_low;
  assign nDTACK_OUT = !dtack_low;
  assign WR_STB     = wr_stb_q;
  assign WR_IDX     = wr_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_m68k_bus_responder.sv
// ============================================================================
// tb_m68k_bus_responder : table-driven, directed and random checks of the responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_m68k_bus_responder;

`ifdef M68K_RESP_BERR_EN
  localparam bit BERR_EN = 1'b1;
`else
  localparam bit BERR_EN = 1'b0;
`endif
  localparam int          WAITC  = 2;
  // 2 synchronizer edges + DECODE + WAITC + 1, counted from the first edge after drive
  localparam int          LAT    = WAITC + 4;
  localparam logic [15:0] ID_VAL = 16'hB16A;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [22:0]  a;
  logic [15:0]  d;
  logic         rnw, as_n, uds_n, lds_n;
  logic [15:0]  d_out;
  logic         d_oe, dtack_out, dtack_oe, berr_out, berr_oe;
  logic [127:0] regs_q;
  logic         wr_stb;
  logic [3:0]   wr_idx;

  always #5 clk = ~clk;

  m68k_bus_responder #(
    .BASE_ADDR   (23'h760000),
    .ADDR_BITS   (4),
    .REG_COUNT   (8),
    .WAIT_CYCLES (WAITC),
    .ID_VALUE    (16'hB16A)
  ) dut (
    .SYS_CLK    (clk),
    .nRESET     (rst_n),
    .A_IN       (a),
    .D_IN       (d),
    .RnW_IN     (rnw),
    .nAS_IN     (as_n),
    .nUDS_IN    (uds_n),
    .nLDS_IN    (lds_n),
    .D_OUT      (d_out),
    .D_OE       (d_oe),
    .nDTACK_OUT (dtack_out),
    .nDTACK_OE  (dtack_oe),
    .nBERR_OUT  (berr_out),
    .nBERR_OE   (berr_oe),
    .REGS_Q     (regs_q),
    .WR_STB     (wr_stb),
    .WR_IDX     (wr_idx)
  );

  int tests = 0;
  int fails = 0;

  logic [15:0] model [16];
  logic [22:0] base_v = 23'h760000;

  int       wr_cnt = 0;
  logic [3:0] wr_idx_last = '0;
  logic     oe_seen = 1'b0;

  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      wr_cnt++;
      wr_idx_last = wr_idx;
    end
    if (d_oe || dtack_oe || berr_oe) oe_seen = 1'b1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    f[15:0] = ID_VAL;
    for (int i = 1; i < 8; i++) f[16*i +: 16] = model[i];
    return f;
  endfunction

  function automatic logic [15:0] model_read(input logic [3:0] idx);
    if (idx == 4'd0) return ID_VAL;
    if (idx < 4'd8)  return model[idx];
    return 16'h0000;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_d_oe"},     d_oe, 1'b0);
    check({tag, "_d_out"},    d_out, 16'h0000);
    check({tag, "_dtack_oe"}, dtack_oe, 1'b0);
    check({tag, "_dtack"},    dtack_out, 1'b1);
    check({tag, "_berr_oe"},  berr_oe, 1'b0);
    check({tag, "_berr"},     berr_out, 1'b1);
    check({tag, "_wr_stb"},   wr_stb, 1'b0);
    check({tag, "_wr_idx"},   wr_idx, 4'd0);
    check({tag, "_regs"},     regs_q, {112'd0, ID_VAL});
  endtask

  // Runs one bus cycle; resp: 0 none, 1 DTACK, 2 BERR
  task automatic bus_cycle(input logic [22:0] addr, input logic rd, input logic un,
                           input logic ln, input logic [15:0] wd,
                           output int lat, output int resp, output logic got_doe,
                           output logic [15:0] got_d, output logic rel_ok);
    lat = 0; resp = 0; got_doe = 1'b0; got_d = '0;
    @(negedge clk);
    a = addr; d = wd; rnw = rd; as_n = 1'b0; uds_n = un; lds_n = ln;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if ((dtack_oe && !dtack_out) || (berr_oe && !berr_out)) begin
        lat     = n;
        resp    = (berr_oe && !berr_out) ? 2 : 1;
        got_doe = d_oe;
        got_d   = d_out;
        break;
      end
    end
    @(negedge clk);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rnw = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rel_ok = !d_oe && !dtack_oe && !berr_oe && dtack_out && berr_out;
  endtask

  task automatic run_and_check(input string tag, input logic [22:0] addr, input logic rd,
                               input logic un, input logic ln, input logic [15:0] wd,
                               output int resp, output logic [15:0] got_d);
    int lat;
    logic got_doe, rel_ok, hit, err, berr, cmt;
    logic [3:0] idx;
    logic [15:0] exp_rd;
    hit = (addr[22:4] == base_v[22:4]);
    idx = addr[3:0];
    exp_rd = model_read(idx);
    wr_cnt = 0;
    oe_seen = 1'b0;
    bus_cycle(addr, rd, un, ln, wd, lat, resp, got_doe, got_d, rel_ok);
    if (!hit) begin
      check({tag, "_miss_no_oe"}, oe_seen, 1'b0);
      check({tag, "_miss_no_wr"}, wr_cnt, 0);
    end else begin
      err  = (!rd && idx == 4'd0) || (idx >= 4'd8);
      berr = BERR_EN && err;
      cmt  = !rd && !err;
      check({tag, "_latency"}, lat, LAT);
      check({tag, "_resp"}, resp, berr ? 2 : 1);
      if (rd && !berr) begin
        check({tag, "_d_oe"}, got_doe, 1'b1);
        check({tag, "_rdata"}, got_d, exp_rd);
      end else begin
        check({tag, "_no_d_oe"}, got_doe, 1'b0);
      end
      if (cmt) begin
        if (!un) model[idx][15:8] = wd[15:8];
        if (!ln) model[idx][7:0]  = wd[7:0];
      end
      check({tag, "_wr_cnt"}, wr_cnt, cmt ? 1 : 0);
      if (cmt) check({tag, "_wr_idx"}, wr_idx_last, idx);
      check({tag, "_release"}, rel_ok, 1'b1);
    end
    check({tag, "_regs"}, regs_q, model_flat());
  endtask

  typedef struct {
    logic [22:0] addr;
    logic        rd;
    logic        un;
    logic        ln;
    logic [15:0] wd;
    int          exp_resp;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int resp;
    int lat;
    logic [15:0] got;
    logic [22:0] addr;
    logic rd, un, ln, ok;

    for (int i = 0; i < 16; i++) model[i] = 16'h0000;

    vecs.push_back('{23'h760000, 1'b1, 1'b0, 1'b0, 16'h0000, 1, 16'hB16A});
    vecs.push_back('{23'h760003, 1'b0, 1'b0, 1'b1, 16'h1234, 1, 16'h0000});
    vecs.push_back('{23'h760003, 1'b1, 1'b0, 1'b0, 16'h0000, 1, 16'h1200});
    vecs.push_back('{23'h760003, 1'b0, 1'b1, 1'b0, 16'hAB56, 1, 16'h0000});
    vecs.push_back('{23'h760003, 1'b1, 1'b0, 1'b0, 16'h0000, 1, 16'h1256});
    vecs.push_back('{23'h123456, 1'b1, 1'b0, 1'b0, 16'h0000, 0, 16'h0000});
    vecs.push_back('{23'h760000, 1'b0, 1'b0, 1'b0, 16'hFFFF, BERR_EN ? 2 : 1, 16'h0000});
    vecs.push_back('{23'h760000, 1'b1, 1'b0, 1'b0, 16'h0000, 1, 16'hB16A});
    vecs.push_back('{23'h760009, 1'b1, 1'b0, 1'b0, 16'h0000, BERR_EN ? 2 : 1, 16'h0000});
    vecs.push_back('{23'h760007, 1'b0, 1'b0, 1'b0, 16'hBEEF, 1, 16'h0000});
    vecs.push_back('{23'h760007, 1'b1, 1'b1, 1'b0, 16'h0000, 1, 16'hBEEF});
    vecs.push_back('{23'h76000F, 1'b0, 1'b0, 1'b0, 16'h5555, BERR_EN ? 2 : 1, 16'h0000});

    rst_n = 1'b0; a = '0; d = '0; rnw = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rd, vecs[i].un,
                    vecs[i].ln, vecs[i].wd, resp, got);
      check($sformatf("vec%0d_tbl_resp", i), resp, vecs[i].exp_resp);
      if (vecs[i].rd && vecs[i].exp_resp == 1)
        check($sformatf("vec%0d_tbl_data", i), got, vecs[i].exp_d);
    end

    // Abort during WAIT on a write to idx 2
    run_and_check("pre_abort", 23'h760002, 1'b0, 1'b0, 1'b0, 16'h5A5A, resp, got);
    wr_cnt = 0;
    oe_seen = 1'b0;
    @(negedge clk);
    a = 23'h760002; d = 16'hFFFF; rnw = 1'b0; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rnw = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_oe", oe_seen, 1'b0);
    check("abort_no_wr", wr_cnt, 0);
    check("abort_reg2", regs_q[47:32], 16'h5A5A);
    run_and_check("post_abort", 23'h760002, 1'b1, 1'b0, 1'b0, 16'h0000, resp, got);

    // Reset while a read of idx 3 sits in ACK
    @(negedge clk);
    a = 23'h760003; rnw = 1'b1; as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (dtack_oe && !dtack_out) begin
        ok = 1'b1;
        break;
      end
    end
    check("midack_reached", ok, 1'b1);
    check("midack_d_oe", d_oe, 1'b1);
    @(negedge clk);
    rst_n = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    @(posedge clk); #1;
    check_reset_state("midack_rst");
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_and_check("after_rst", 23'h760000, 1'b1, 1'b0, 1'b0, 16'h0000, resp, got);

    // Random traffic against the reference model
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 9) < 8) addr = {base_v[22:4], 4'($urandom_range(0, 15))};
      else                          addr = 23'($urandom);
      rd = 1'($urandom);
      un = 1'($urandom);
      ln = 1'($urandom);
      if (!rd && un && ln) ln = 1'b0;
      run_and_check($sformatf("rnd%0d", t), addr, rd, un, ln, 16'($urandom), resp, got);
    end

    lat = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
